// File: rtl/mole_pkg.sv
// mole_pkg: shared FSM states, LFSR constants and score limits for mole_engine
package mole_pkg;
  typedef enum logic [1:0] {IDLE, SPAWN, UP, GAP} state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  localparam int SCORE_W = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) loaded with seed on reset
module lfsr16
  import mole_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) q <= seed;
    else q <= {q[14:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/mole_engine.sv
// mole_engine: pops pseudo-random moles while play is high and keeps a saturating hit score.
// Define MOLE_ENGINE_PENALTY_EN to make wrong-hole whacks cost a point and pulse miss.
module mole_engine
  import mole_pkg::*;
#(
  parameter int          NUM_HOLES   = 8,
  parameter int          MOLE_CYCLES = 25000000,
  parameter int          GAP_CYCLES  = 12500000,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 play,
  input  logic                 display_score,
  input  logic [NUM_HOLES-1:0] whack,
  output logic [NUM_HOLES-1:0] mole_leds,
  output logic [SCORE_W-1:0]   score,
  output logic                 hit,
  output logic                 miss,
  output logic                 busy
);
  localparam int IW = $clog2(NUM_HOLES);
  localparam int CMAX = MOLE_CYCLES > GAP_CYCLES ? MOLE_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  state_t state, state_n;
  logic [15:0] lfsr;
  logic [NUM_HOLES-1:0] whack_q, rise, cur_oh, leds_d;
  logic [IW-1:0] cur_idx, raw_idx, new_idx;
  logic [CW-1:0] cnt, cnt_d;
  logic [SCORE_W-1:0] score_d;
  logic abort, timeout, gap_done, up_live, hit_d, miss_d, pen, unused_lfsr;

  lfsr16 u_lfsr (.CLOCK_50(CLOCK_50), .reset(reset), .seed(LFSR_SEED), .q(lfsr));

  assign unused_lfsr = ^lfsr[15:IW];
  assign rise = whack & ~whack_q;
  assign cur_oh = NUM_HOLES'(1) << cur_idx;
  assign raw_idx = lfsr[IW-1:0];
  // cur_idx doubles as the previous hole, so a repeat is bumped to the next hole
  assign new_idx = raw_idx == cur_idx ? raw_idx + IW'(1) : raw_idx;
  assign abort = ~play | display_score;
  assign timeout = cnt == CW'(MOLE_CYCLES - 1);
  assign gap_done = cnt == CW'(GAP_CYCLES - 1);
  assign busy = state != IDLE;

  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = abort ? IDLE : SPAWN;
      SPAWN:   state_n = abort ? IDLE : UP;
      UP:      state_n = abort ? IDLE : (rise[cur_idx] || timeout) ? GAP : UP;
      GAP:     state_n = abort ? IDLE : gap_done ? SPAWN : GAP;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    up_live = state == UP && !abort;
    hit_d = up_live && rise[cur_idx];
`ifdef MOLE_ENGINE_PENALTY_EN
    pen = up_live && !hit_d && |(rise & ~cur_oh);
`else
    pen = 1'b0;
`endif
    miss_d = up_live && !hit_d && (timeout || pen);
    score_d = (state == IDLE && state_n == SPAWN) ? '0
            : (hit_d && score != SCORE_MAX) ? score + 1'b1
            : (pen && score != '0) ? score - 1'b1 : score;
    cnt_d = (state_n == state && (state == UP || state == GAP)) ? cnt + 1'b1 : '0;
    leds_d = state_n == UP ? NUM_HOLES'(1) << (state == SPAWN ? new_idx : cur_idx) : '0;
  end

  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      whack_q <= '0;
      cur_idx <= '0;
      cnt <= '0;
      score <= '0;
      hit <= 1'b0;
      miss <= 1'b0;
      mole_leds <= '0;
    end else begin
      whack_q <= whack;
      cnt <= cnt_d;
      score <= score_d;
      hit <= hit_d;
      miss <= miss_d;
      mole_leds <= leds_d;
      if (state == SPAWN) cur_idx <= new_idx;
    end
endmodule

// File: doc/mole_engine.md
Name: mole_engine

Overview:
- Game-play datapath downstream of the game controller's `play` strobe, running alongside the round timer.
- While `play` is high, pops one mole at a time at a pseudo-random hole and drives a one-hot LED vector.
- Detects whacks on the player buttons and keeps a saturating hit score, which the display path shows once `display_score` asserts.

Parameters:
- NUM_HOLES, 8, number of holes/buttons; must be 2, 4, 8 or 16.
- MOLE_CYCLES, 25000000, clock cycles a mole stays up before it counts as a miss.
- GAP_CYCLES, 12500000, clock cycles with no mole between pops.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- play  input  1  round active, level, from game controller.
- display_score  input  1  freeze request; score held, no moles.
- whack  input  NUM_HOLES  player buttons, active-high, already synchronised to CLOCK_50.
- mole_leds  output  NUM_HOLES  one-hot mole position; all zero when no mole.
- score  output  8  hits this round, binary, saturating.
- hit  output  1  one-cycle pulse on a valid whack.
- miss  output  1  one-cycle pulse on mole timeout.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE, mole_leds 0, score 0, hit 0, miss 0, busy 0, LFSR = LFSR_SEED, whack edge register 0, prev_idx 0.
- Clocking: all registers are on posedge CLOCK_50 and async-clear on reset; reset mid-round aborts immediately.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle regardless of state.
- Whack edges: whack_rise = whack & ~whack_q. Only rising edges count; a held button never counts twice.
- Hole index: idx = lfsr[log2(NUM_HOLES)-1:0]. If idx == prev_idx, use idx+1 modulo NUM_HOLES, so the same hole never appears twice in a row.
- IDLE:
  - play=1 and display_score=0 -> SPAWN; score cleared to 0 on this transition.
  - Otherwise stay in IDLE; score holds.
- SPAWN (1 cycle): latch the hole index into cur_idx and prev_idx, clear the counter -> UP.
- UP:
  - mole_leds = 1<<cur_idx, registered, so the LED turns on the cycle after SPAWN.
  - The counter increments each cycle.
  - whack_rise[cur_idx]=1 -> hit pulse, score+1 (saturates at 255) -> GAP.
  - Otherwise, counter == MOLE_CYCLES-1 -> miss pulse -> GAP.
  - If a hit and the timeout occur in the same cycle, the hit wins.
- GAP:
  - mole_leds 0; counter restarts from 0.
  - counter == GAP_CYCLES-1: -> SPAWN if play, else IDLE.
- Ignored whacks: any whack edge in IDLE, SPAWN or GAP, or on a non-mole hole in UP (see Optional Feature).
- Abort: play=0 or display_score=1 in any non-IDLE state -> IDLE on the next edge. mole_leds clear, score is kept (frozen for display), and no hit/miss pulse fires for the aborted mole.
- Pulses: hit and miss are registered and never both high. busy = (state != IDLE).

Optional Feature:
- Macro: MOLE_ENGINE_PENALTY_EN.
- Defined: in UP, a whack_rise on any hole other than cur_idx decrements score, saturating at 0, and also asserts miss for one cycle; the mole stays up. If the correct hole and a wrong hole both rise in the same cycle, it counts as a hit only, with no penalty.
- Undefined: wrong-hole whacks are ignored and score never decrements.

Decomposition:
- Shared package mole_pkg:
  - state enum: IDLE, SPAWN, UP, GAP.
  - LFSR tap mask and default seed.
  - SCORE_W=8 and SCORE_MAX=255.
- One sub-module, lfsr16, with ports CLOCK_50, reset, seed, q[15:0]; it free-runs.
- Counter, FSM, edge detect and scoring stay in mole_engine.

Test Plan (bench uses NUM_HOLES=4, MOLE_CYCLES=8, GAP_CYCLES=4, default seed):
- Reset and start: reset for 3 cycles, then play=1 -> SPAWN next edge, mole_leds one-hot 2 cycles after play rises, score=0, busy=1.
- Hit: whack the lit hole 3 cycles into UP -> hit=1 for one cycle, score=1, mole_leds=0 next cycle, next mole after 4 GAP cycles at a different hole.
- Timeout: no whack -> miss=1 exactly 8 cycles after UP entry, score unchanged, GAP follows.
- Hold and wrong hole: hold the correct button across two moles -> scored once. Whack a wrong hole -> no score change, or score-1 floored at 0 with miss, when MOLE_CYCLES_PENALTY... macro MOLE_ENGINE_PENALTY_EN is defined.
- Saturation and abort: force 260 hits -> score stays 255. Drop play mid-UP -> IDLE next edge, leds 0, score kept, no pulse.
- Async reset mid-round: assert reset between clock edges during UP -> outputs clear immediately, without waiting for a clock edge.
